crack_result_arbiter: RTL and testbench
=======================================

CRACK_RESULT_ARBITER -- requirements
Module: crack_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of parallel RC4 key-search cores.
REQ-002 SHALL have parameter LOG_NUM_CORES, default 2: width of the core index.
REQ-003 SHALL have parameter KEY_WIDTH, default 24: width of a candidate key.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: single-cycle request to begin a new search.
REQ-007 SHALL have port core_done  input  NUM_CORES: bit i high means core i has exhausted its key range.
REQ-008 SHALL have port core_found  input  NUM_CORES: bit i high means core i decrypted valid plaintext this cycle.
REQ-009 SHALL have port core_key  input  NUM_CORES*KEY_WIDTH: core i key in bits [i*KEY_WIDTH +: KEY_WIDTH].
REQ-010 SHALL have port stop_cores  output  1: high means all cores halt.
REQ-011 SHALL have port result_valid  output  1: high means the result fields are stable.
REQ-012 SHALL have port result_found  output  1: high means a key was found; low means the key space was exhausted.
REQ-013 SHALL have port result_core  output  LOG_NUM_CORES: index of the winning core.
REQ-014 SHALL have port result_key  output  KEY_WIDTH: the winning key.
REQ-015 SHALL have port result_ack  input  1: the consumer has taken the result.

Function
REQ-016 SHALL implement FSM states IDLE, SEARCH, SELECT and HOLD.
REQ-017 SHALL, in IDLE, go to SEARCH on start=1 and clear found_reg, done_reg and all captured keys on that edge.
REQ-018 SHALL ignore start in SEARCH, SELECT and HOLD.
REQ-019 SHALL, in SEARCH only, on every edge: found_reg[i] |= core_found[i]; done_reg[i] |= core_done[i].
REQ-020 SHALL capture core i's key slice into key_reg[i] on the edge where found_reg[i] goes 0->1; later pulses from core i SHALL NOT overwrite key_reg[i].
REQ-021 SHALL go SEARCH->SELECT on the edge after found_reg becomes nonzero; found_reg SHALL NOT update in SELECT or HOLD.
REQ-022 SHALL go SEARCH->HOLD with result_found=0, result_core=0 and result_key=0 when done_reg is all-ones and found_reg is zero.
REQ-023 SHALL give priority to found: when found_reg is nonzero and done_reg is all-ones, the FSM SHALL go to SELECT.
REQ-024 SHALL, in SELECT, load result_core with the index of the least-significant set bit of found_reg and result_key with key_reg of that index, set result_found=1, and go to HOLD.
REQ-025 SHALL choose the lowest index when several cores are found on the same edge.
REQ-026 SHALL give a latency of exactly 2 edges from the edge that samples core_found to result_valid=1.
REQ-027 SHALL assert stop_cores combinationally in SELECT and HOLD, and deassert it in IDLE and SEARCH.
REQ-028 SHALL hold result_valid=1 in HOLD only, with result fields constant while it is high.
REQ-029 SHALL go HOLD->IDLE on result_ack=1; result_ack SHALL be ignored outside HOLD.
REQ-030 SHALL keep result fields in IDLE until the next start, which clears them to 0.

Reset
REQ-031 SHALL, on reset=1 at any time including mid-search, force the state to IDLE.
REQ-032 SHALL, on reset, clear found_reg, done_reg and key_reg.
REQ-033 SHALL, on reset, drive stop_cores=0, result_valid=0, result_found=0, result_core=0 and result_key=0, without waiting for clk.

Verification
REQ-034 SHALL cover: NUM_CORES=4, start; at cycle 10 core_found=4'b0100 with core 2 key 24'h0A1B2C -> 2 edges later result_valid=1, result_found=1, result_core=2, result_key=24'h0A1B2C, stop_cores=1.
REQ-035 SHALL cover: core_found=4'b1010 on one edge -> result_core=1, core 1 key reported.
REQ-036 SHALL cover: core_done pulses 0001, 0010, 1100 on separate edges with no found -> HOLD with result_found=0, result_core=0, result_key=0.
REQ-037 SHALL cover: core_found[3] and the final core_done bit on the same edge -> result_found=1, result_core=3.
REQ-038 SHALL cover: result_ack held low for 20 cycles with start pulsed during HOLD -> outputs unchanged, start ignored; result_ack=1 -> IDLE next edge, stop_cores=0.
REQ-039 SHALL cover: reset asserted mid-SEARCH between clock edges, with found_reg nonzero -> all outputs 0 immediately; next start runs a fresh search with no stale found bits.

Source files
------------

// File: rtl/crack_result_arbiter_if.sv
// Handshake/bus bundle between the crack result arbiter and its environment
// (key-search cores plus the result consumer).
//   start        : single-cycle request to begin a new search
//   core_done    : per-core "key range exhausted" flags
//   core_found   : per-core "valid plaintext this cycle" pulses
//   core_key     : per-core candidate keys, core i at [i*KEY_WIDTH +: KEY_WIDTH]
//   stop_cores   : halt all cores
//   result_valid : result fields are stable
//   result_found : 1 = key found, 0 = key space exhausted
//   result_core  : index of the winning core
//   result_key   : winning key
//   result_ack   : consumer has taken the result
// master = arbiter side, slave = cores/consumer side.
interface crack_result_arbiter_if #(
  parameter int unsigned NUM_CORES     = 4,
  parameter int unsigned LOG_NUM_CORES = 2,
  parameter int unsigned KEY_WIDTH     = 24
);
  logic                           start;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_found;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic                           stop_cores;
  logic                           result_valid;
  logic                           result_found;
  logic [LOG_NUM_CORES-1:0]       result_core;
  logic [KEY_WIDTH-1:0]           result_key;
  logic                           result_ack;

  modport master (
    input  start, core_done, core_found, core_key, result_ack,
    output stop_cores, result_valid, result_found, result_core, result_key
  );

  modport slave (
    output start, core_done, core_found, core_key, result_ack,
    input  stop_cores, result_valid, result_found, result_core, result_key
  );
endinterface

// File: rtl/crack_result_arbiter.sv
// Collects found/done flags from parallel RC4 key-search cores, picks the
// lowest-indexed core that found a key (or reports exhaustion), halts the
// cores and holds the result until acknowledged.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : crack_result_arbiter_if.master (start, core_*, result_*, stop_cores)
module crack_result_arbiter #(
  parameter int unsigned NUM_CORES     = 4,
  parameter int unsigned LOG_NUM_CORES = 2,
  parameter int unsigned KEY_WIDTH     = 24
) (
  input logic                     clk,
  input logic                     reset,
  crack_result_arbiter_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StSelect, StHold} state_e;

  state_e                   state_q, state_d;
  logic [NUM_CORES-1:0]     found_q, found_d;
  logic [NUM_CORES-1:0]     done_q, done_d;
  logic [KEY_WIDTH-1:0]     key_q [NUM_CORES];
  logic [KEY_WIDTH-1:0]     key_d [NUM_CORES];
  logic                     result_found_q, result_found_d;
  logic [LOG_NUM_CORES-1:0] result_core_q, result_core_d;
  logic [KEY_WIDTH-1:0]     result_key_q, result_key_d;

  logic [LOG_NUM_CORES-1:0] win_idx;
  logic [KEY_WIDTH-1:0]     win_key;

  // Lowest set bit of found_q wins; scan downward so the lowest index is last.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (found_q[i]) win_idx = LOG_NUM_CORES'(i);
    end
  end

  assign win_key = key_q[win_idx];

  always_comb begin
    state_d        = state_q;
    found_d        = found_q;
    done_d         = done_q;
    key_d          = key_q;
    result_found_d = result_found_q;
    result_core_d  = result_core_q;
    result_key_d   = result_key_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d        = StSearch;
          found_d        = '0;
          done_d         = '0;
          for (int i = 0; i < NUM_CORES; i++) key_d[i] = '0;
          result_found_d = 1'b0;
          result_core_d  = '0;
          result_key_d   = '0;
        end
      end
      StSearch: begin
        found_d = found_q | bus.core_found;
        done_d  = done_q | bus.core_done;
        // Only the first found pulse of a core captures its key.
        for (int i = 0; i < NUM_CORES; i++) begin
          if (bus.core_found[i] && !found_q[i]) begin
            key_d[i] = bus.core_key[i*KEY_WIDTH +: KEY_WIDTH];
          end
        end
        // A found key beats exhaustion.
        if (|found_q) begin
          state_d = StSelect;
        end else if (&done_q) begin
          state_d        = StHold;
          result_found_d = 1'b0;
          result_core_d  = '0;
          result_key_d   = '0;
        end
      end
      StSelect: begin
        state_d        = StHold;
        result_found_d = 1'b1;
        result_core_d  = win_idx;
        result_key_d   = win_key;
      end
      StHold: begin
        if (bus.result_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      found_q        <= '0;
      done_q         <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
      result_found_q <= 1'b0;
      result_core_q  <= '0;
      result_key_q   <= '0;
    end else begin
      state_q        <= state_d;
      found_q        <= found_d;
      done_q         <= done_d;
      key_q          <= key_d;
      result_found_q <= result_found_d;
      result_core_q  <= result_core_d;
      result_key_q   <= result_key_d;
    end
  end

  assign bus.stop_cores   = (state_q == StSelect) || (state_q == StHold);
  assign bus.result_valid = (state_q == StHold);
  assign bus.result_found = result_found_q;
  assign bus.result_core  = result_core_q;
  assign bus.result_key   = result_key_q;

endmodule

// File: tb/tb_crack_result_arbiter.sv
module tb_crack_result_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  crack_result_arbiter_if #(.NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24)) bus ();

  crack_result_arbiter #(.NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic stop, input logic valid,
                               input logic found, input logic [1:0] core,
                               input logic [23:0] key);
    check({tag, ".stop_cores"}, 32'(bus.stop_cores), 32'(stop));
    check({tag, ".result_valid"}, 32'(bus.result_valid), 32'(valid));
    check({tag, ".result_found"}, 32'(bus.result_found), 32'(found));
    check({tag, ".result_core"}, 32'(bus.result_core), 32'(core));
    check({tag, ".result_key"}, 32'(bus.result_key), 32'(key));
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.core_done   = '0;
    bus.core_found  = '0;
    bus.core_key    = {24'hDEAD03, 24'hDEAD02, 24'hDEAD01, 24'hDEAD00};
    bus.result_ack  = 1'b0;

    #3;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 2'd0, 24'h0);
    step();
    reset = 1'b0;

    // Single core found at cycle 10.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t1.search_stop", 32'(bus.stop_cores), 32'd0);
    repeat (8) step();
    bus.core_found = 4'b0100;
    bus.core_key[2*24 +: 24] = 24'h0A1B2C;
    step();
    bus.core_found = '0;
    bus.core_key[2*24 +: 24] = 24'h555555;
    check("t1.e1_valid", 32'(bus.result_valid), 32'd0);
    step();
    check("t1.e2_stop", 32'(bus.stop_cores), 32'd1);
    check("t1.e2_valid", 32'(bus.result_valid), 32'd0);
    step();
    check_outputs("t1.hold", 1'b1, 1'b1, 1'b1, 2'd2, 24'h0A1B2C);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    check_outputs("t1.idle", 1'b0, 1'b0, 1'b1, 2'd2, 24'h0A1B2C);

    // Two cores found together; lowest index wins, later pulse ignored.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_outputs("t2.cleared", 1'b0, 1'b0, 1'b0, 2'd0, 24'h0);
    bus.core_found = 4'b1010;
    bus.core_key[1*24 +: 24] = 24'h111111;
    bus.core_key[3*24 +: 24] = 24'h333333;
    step();
    bus.core_found = 4'b0010;
    bus.core_key[1*24 +: 24] = 24'h999999;
    step();
    bus.core_found = '0;
    step();
    check_outputs("t2.hold", 1'b1, 1'b1, 1'b1, 2'd1, 24'h111111);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;

    // Exhaustion with no find.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.core_done = 4'b0001;
    step();
    bus.core_done = 4'b0010;
    step();
    bus.core_done = 4'b1100;
    step();
    bus.core_done = '0;
    check("t3.pre_valid", 32'(bus.result_valid), 32'd0);
    step();
    check_outputs("t3.hold", 1'b1, 1'b1, 1'b0, 2'd0, 24'h0);

    // Held result survives 20 cycles without ack and ignores start.
    for (int i = 0; i < 20; i++) begin
      bus.start = (i == 5);
      step();
      check("t3.wait_valid", 32'(bus.result_valid), 32'd1);
      check("t3.wait_stop", 32'(bus.stop_cores), 32'd1);
      check("t3.wait_found", 32'(bus.result_found), 32'd0);
    end
    bus.start = 1'b0;
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    check("t3.ack_valid", 32'(bus.result_valid), 32'd0);
    check("t3.ack_stop", 32'(bus.stop_cores), 32'd0);

    // Found and final done bit on the same edge: found has priority.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.core_done = 4'b0111;
    step();
    bus.core_done = 4'b1000;
    bus.core_found = 4'b1000;
    bus.core_key[3*24 +: 24] = 24'hABCDEF;
    step();
    bus.core_done = '0;
    bus.core_found = '0;
    step();
    step();
    check_outputs("t4.hold", 1'b1, 1'b1, 1'b1, 2'd3, 24'hABCDEF);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;

    // Reset mid-search with a found bit latched, then a fresh search.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.core_found = 4'b0001;
    bus.core_key[0*24 +: 24] = 24'h555555;
    step();
    bus.core_found = '0;
    #2;
    reset = 1'b1;
    #1;
    check_outputs("t5.reset", 1'b0, 1'b0, 1'b0, 2'd0, 24'h0);
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.fresh_stop", 32'(bus.stop_cores), 32'd0);
    end
    bus.core_found = 4'b0100;
    bus.core_key[2*24 +: 24] = 24'h777777;
    step();
    bus.core_found = '0;
    step();
    step();
    check_outputs("t5.hold", 1'b1, 1'b1, 1'b1, 2'd2, 24'h777777);

    // Reset between edges while holding clears outputs immediately.
    #2;
    reset = 1'b1;
    #1;
    check_outputs("t6.reset", 1'b0, 1'b0, 1'b0, 2'd0, 24'h0);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
